// File: rtl/code_sequencer3_pkg.sv
// Shared types and code helpers for the code_sequencer3 block.
package codeseq_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   localparam int unsigned CODE_W = 3;
   localparam logic [CODE_W-1:0] CODE_FIRST = 3'd0;
   localparam logic [CODE_W-1:0] CODE_LAST  = 3'd7;

   function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                   input logic down);
      return down ? code - 3'd1 : code + 3'd1;
   endfunction

   // Last code of a pass; advancing from it is the wrap point.
   function automatic logic [CODE_W-1:0] end_code(input logic down);
      return down ? CODE_FIRST : CODE_LAST;
   endfunction

   function automatic logic [CODE_W-1:0] begin_code(input logic down);
      return down ? CODE_LAST : CODE_FIRST;
   endfunction

endpackage

// File: rtl/code_sequencer3_if.sv
// Control/status bundle between a controller (master) and code_sequencer3 (slave).
// The dir signal exists only when CODESEQ_DIR_EN is defined.
interface code_sequencer3_if #(
   parameter int unsigned DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic               step;
   logic               loop;
   logic [DWELL_W-1:0] dwell;
`ifdef CODESEQ_DIR_EN
   logic               dir;
`endif
   logic               A;
   logic               B;
   logic               C;
   logic               busy;
   logic               wrap;
   logic               done;

`ifdef CODESEQ_DIR_EN
   modport master (output start, stop, step, loop, dwell, dir,
                   input  A, B, C, busy, wrap, done);
   modport slave  (input  start, stop, step, loop, dwell, dir,
                   output A, B, C, busy, wrap, done);
`else
   modport master (output start, stop, step, loop, dwell,
                   input  A, B, C, busy, wrap, done);
   modport slave  (input  start, stop, step, loop, dwell,
                   output A, B, C, busy, wrap, done);
`endif

endinterface

// File: rtl/code_sequencer3_dwell_timer.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
module dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic [DWELL_W-1:0] load_val,
   output logic               zero
);

   localparam logic [DWELL_W-1:0] ONE = 1;

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/code_sequencer3.sv
// Timed 3-bit code sequencer feeding the 3-to-5 group decoder.
// Define CODESEQ_DIR_EN to add the dir input for down-counting.
module code_sequencer3
   import codeseq_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
) (
   input logic               clk,
   input logic               rst,
   code_sequencer3_if.slave  bus
);

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                busy_q, busy_d;
   logic                wrap_q, wrap_d;
   logic                done_q, done_d;

   logic                tmr_load;
   logic                tmr_en;
   logic                tmr_zero;
   logic [DWELL_W-1:0]  tmr_val;

   logic                down;
   logic                run_tick;
   logic                do_step;
   logic                at_end;

`ifdef CODESEQ_DIR_EN
   assign down = bus.dir;
`else
   assign down = 1'b0;
`endif

   assign at_end = (code_q == end_code(down));

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      wrap_d   = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = bus.dwell;
      run_tick = 1'b0;
      do_step  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!bus.stop) begin
               if (bus.start) begin
                  state_d  = S_RUN;
                  code_d   = begin_code(down);
                  tmr_load = 1'b1;
               end else if (bus.step) begin
                  do_step = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_PAUSE;
            end else begin
               run_tick = 1'b1;
            end
         end
         S_PAUSE: begin
            if (bus.stop) begin
               state_d  = S_IDLE;
               code_d   = CODE_FIRST;
               tmr_load = 1'b1;
               tmr_val  = '0;
            end else if (bus.start) begin
               // Resuming edge counts as a RUN cycle on the held counter.
               state_d  = S_RUN;
               run_tick = 1'b1;
            end else if (bus.step) begin
               do_step = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_step) begin
         code_d   = next_code(code_q, down);
         tmr_load = 1'b1;
         wrap_d   = at_end;
      end

      if (run_tick) begin
         if (!tmr_zero) begin
            tmr_en = 1'b1;
         end else if (at_end && !bus.loop) begin
            state_d  = S_IDLE;
            code_d   = CODE_FIRST;
            done_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = '0;
         end else begin
            code_d   = next_code(code_q, down);
            tmr_load = 1'b1;
            wrap_d   = at_end;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         code_q  <= CODE_FIRST;
         busy_q  <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign bus.A    = code_q[2];
   assign bus.B    = code_q[1];
   assign bus.C    = code_q[0];
   assign bus.busy = busy_q;
   assign bus.wrap = wrap_q;
   assign bus.done = done_q;

endmodule
